prio_arbiter_rr: RTL and testbench



---
 rtl/prio_arb_pkg.sv | 13 +
 rtl/prio_arbiter_rr_pick.sv | 52 +++++
 rtl/prio_arbiter_rr.sv | 104 ++++++++++
 tb/tb_prio_arbiter_rr.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// Shared constants and state encoding for the priority / round-robin arbiter.
package prio_arb_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int HOLD_W     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/prio_arbiter_rr_pick.sv
// Combinational winner picker: highest index (fixed) or
// first set bit at/after ptr_i with wrap (round-robin).
module prio_pick
  import prio_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic         mode_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [2*N-1:0] dbl;
  logic [W-1:0]   rr_idx;
  logic [W-1:0]   fx_idx;
  logic           rr_hit;

  // Lower copy masked below ptr, so the first hit in the
  // doubled vector is the wrapped round-robin winner.
  always_comb begin
    dbl = {req_i, req_i};
    for (int i = 0; i < N; i++) begin
      if (i < int'(ptr_i)) dbl[i] = 1'b0;
    end
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!rr_hit && dbl[i]) begin
        rr_hit = 1'b1;
        rr_idx = W'(i >= N ? i - N : i);
      end
    end
  end

  always_comb begin
    fx_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) fx_idx = W'(i);
    end
  end

  always_comb begin
    any_o = |req_i;
    idx_o = (mode_i == 1'(MODE_RR)) ? rr_idx : fx_idx;
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/prio_arbiter_rr.sv
// Registered N-way arbiter, fixed-priority or round-robin, grant held until dropped.
// Define PRIO_ARB_TIMEOUT_EN to bound holds at MAX_HOLD cycles when others wait.
module prio_arbiter_rr
  import prio_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int MODE = MODE_FIXED,
  parameter int MAX_HOLD = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         valid
);

  state_e       state_q;
  logic [N-1:0] grant_q;
  logic [W-1:0] idx_q;
  logic         valid_q;
  logic [W-1:0] rr_ptr_q;
  logic [W-1:0] rr_ptr_d;

  logic [N-1:0] pick_req;
  logic [N-1:0] pick_gnt;
  logic [W-1:0] pick_idx;
  logic         pick_any;
  logic         owner_held;
  logic         to_rearb;
  logic         rearb;

  // Owner bit is always excluded; only matters on a forced timeout.
  assign pick_req   = req & ~grant_q;
  assign owner_held = |(req & grant_q);

  prio_pick #(
    .N(N)
  ) u_pick (
    .req_i (pick_req),
    .ptr_i (rr_ptr_q),
    .mode_i(MODE == MODE_RR),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign rr_ptr_d = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);

`ifdef PRIO_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              hold_hit;

  assign hold_hit = (state_q == BUSY) &&
                    (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign to_rearb = hold_hit && pick_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else if (rearb || hold_hit) begin
      hold_cnt_q <= '0;
    end else if (state_q == BUSY) begin
      hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
    end
  end
`else
  logic [31:0] unused_max_hold;

  assign unused_max_hold = 32'(MAX_HOLD);
  assign to_rearb        = 1'b0;
`endif

  assign rearb = (state_q == IDLE) || !owner_held || to_rearb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else if (rearb) begin
      if (pick_any) begin
        state_q <= BUSY;
        grant_q <= pick_gnt;
        idx_q   <= pick_idx;
        valid_q <= 1'b1;
        if (MODE == MODE_RR) rr_ptr_q <= rr_ptr_d;
      end else begin
        state_q <= IDLE;
        grant_q <= '0;
        idx_q   <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Bench for prio_arbiter_rr: fixed N=4 and round-robin N=3 instances
// against a cycle-level behavioural model of the arbitration rules.
module tb_prio_arbiter_rr;

`ifdef PRIO_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_f = '0;
  logic [2:0] req_r = '0;
  logic [3:0] grant_f;
  logic [1:0] idx_f;
  logic       valid_f;
  logic [2:0] grant_r;
  logic [1:0] idx_r;
  logic       valid_r;

  int own_f = -1, ptr_f = 0, cnt_f = 0;
  int own_r = -1, ptr_r = 0, cnt_r = 0;
  int n_cmp = 0;
  int n_bad = 0;

  prio_arbiter_rr #(.N(4), .MODE(0), .MAX_HOLD(16)) u_fix (
    .clk(clk), .rst(rst), .req(req_f),
    .grant(grant_f), .grant_idx(idx_f), .valid(valid_f)
  );

  prio_arbiter_rr #(.N(3), .MODE(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst(rst), .req(req_r),
    .grant(grant_r), .grant_idx(idx_r), .valid(valid_r)
  );

  always #5 clk = ~clk;

  task automatic model_step(input int n, input int mode, input int maxh,
                            input int r, inout int own, inout int ptr,
                            inout int cnt);
    bit others;
    bit go;
    int w;
    int j;
    others = 0;
    for (int k = 0; k < n; k++) if (k != own && r[k]) others = 1;
    if (own < 0) go = 1;
    else go = !r[own] || (TO_EN && cnt == maxh - 1 && others);
    if (go) begin
      w = -1;
      if (mode == 0) begin
        for (int k = 0; k < n; k++) if (r[k] && k != own) w = k;
      end else begin
        for (int k = 0; k < n; k++) begin
          j = (ptr + k) % n;
          if (w < 0 && r[j] && j != own) w = j;
        end
      end
      own = w;
      cnt = 0;
      if (w >= 0 && mode == 1) ptr = (w + 1) % n;
    end else if (TO_EN && cnt == maxh - 1) begin
      cnt = 0;
    end else begin
      cnt++;
    end
  endtask

  function automatic logic [6:0] exp_f();
    if (own_f < 0) return 7'd0;
    return {1'b1, 2'(own_f), 4'(1 << own_f)};
  endfunction

  function automatic logic [5:0] exp_r();
    if (own_r < 0) return 6'd0;
    return {1'b1, 2'(own_r), 3'(1 << own_r)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step(4, 0, 16, int'(req_f), own_f, ptr_f, cnt_f);
    model_step(3, 1, 4, int'(req_r), own_r, ptr_r, cnt_r);
    #1;
  endtask

  task automatic model_reset();
    own_f = -1; ptr_f = 0; cnt_f = 0;
    own_r = -1; ptr_r = 0; cnt_r = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({valid_f, idx_f, grant_f} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_fix: got %h want 00", {valid_f, idx_f, grant_f});
    end
    n_cmp++;
    if ({valid_r, idx_r, grant_r} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_rr: got %h want 00", {valid_r, idx_r, grant_r});
    end
    @(negedge clk);
    rst = 1'b0;
    req_f = 4'b0001;
    step();
    step();
    n_cmp++;
    if ({valid_f, idx_f, grant_f} !== 7'b1_00_0001) begin
      n_bad++;
      $display("FAIL pre_reset_grant: got %h want 41", {valid_f, idx_f, grant_f});
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({valid_f, grant_f} !== 5'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %h want 00", {valid_f, grant_f});
    end
    @(negedge clk);
    rst = 1'b0;
    req_f = '0;
    repeat (3) begin
      step();
      n_cmp++;
      if ({valid_f, idx_f, grant_f} !== 7'd0) begin
        n_bad++;
        $display("FAIL idle_after_reset: got %h want 00", {valid_f, idx_f, grant_f});
      end
    end
  endtask

  task automatic test_encoder();
    logic [3:0] pat[7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                           4'b1001, 4'b0110, 4'b1111};
    int eidx[7] = '{0, 1, 2, 3, 3, 2, 3};
    for (int i = 0; i < 7; i++) begin
      req_f = pat[i];
      step();
      n_cmp++;
      if ({valid_f, idx_f} !== {1'b1, 2'(eidx[i])}) begin
        n_bad++;
        $display("FAIL encoder[%0d]: got v%b idx%0d want v1 idx%0d",
                 i, valid_f, idx_f, eidx[i]);
      end
      n_cmp++;
      if ({valid_f, idx_f, grant_f} !== exp_f()) begin
        n_bad++;
        $display("FAIL encoder_model[%0d]: got %h want %h",
                 i, {valid_f, idx_f, grant_f}, exp_f());
      end
      req_f = '0;
      step();
      n_cmp++;
      if (valid_f !== 1'b0) begin
        n_bad++;
        $display("FAIL encoder_drop[%0d]: got v%b want v0", i, valid_f);
      end
    end
  endtask

  task automatic test_handoff();
    logic [3:0] seq[3] = '{4'b0011, 4'b1011, 4'b1001};
    int eidx[3] = '{1, 1, 3};
    for (int i = 0; i < 3; i++) begin
      req_f = seq[i];
      step();
      n_cmp++;
      if ({valid_f, idx_f, grant_f} !== {1'b1, 2'(eidx[i]), 4'(1 << eidx[i])}) begin
        n_bad++;
        $display("FAIL handoff[%0d]: got %h want idx%0d valid", i,
                 {valid_f, idx_f, grant_f}, eidx[i]);
      end
    end
    req_f = '0;
    step();
  endtask

  task automatic test_rr_fair();
    int seq[4] = '{0, 1, 2, 0};
    req_r = 3'b111;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        req_r = 3'b111;
        req_r[seq[i-1]] = 1'b0;
        step();
      end
      n_cmp++;
      if ({valid_r, idx_r, grant_r} !== {1'b1, 2'(seq[i]), 3'(1 << seq[i])}) begin
        n_bad++;
        $display("FAIL rr_fair[%0d]: got %h want idx%0d", i,
                 {valid_r, idx_r, grant_r}, seq[i]);
      end
      req_r = 3'b111;
      step();
      n_cmp++;
      if ({valid_r, idx_r, grant_r} !== exp_r()) begin
        n_bad++;
        $display("FAIL rr_hold[%0d]: got %h want %h", i,
                 {valid_r, idx_r, grant_r}, exp_r());
      end
    end
    req_r = '0;
    step();
  endtask

  task automatic test_timeout();
    req_r = 3'b001;
    step();
    n_cmp++;
    if ({valid_r, idx_r} !== 3'b1_00) begin
      n_bad++;
      $display("FAIL to_first: got v%b idx%0d want v1 idx0", valid_r, idx_r);
    end
    req_r = 3'b011;
`ifdef PRIO_ARB_TIMEOUT_EN
    for (int s = 1; s <= 4; s++) begin
      step();
      n_cmp++;
      if ({valid_r, idx_r} !== {1'b1, 2'(s < 4 ? 0 : 1)}) begin
        n_bad++;
        $display("FAIL to_force[%0d]: got v%b idx%0d want v1 idx%0d",
                 s, valid_r, idx_r, (s < 4 ? 0 : 1));
      end
    end
    req_r = '0;
    step();
    req_r = 3'b001;
    step();
    repeat (10) begin
      step();
      n_cmp++;
      if ({valid_r, idx_r} !== 3'b1_00) begin
        n_bad++;
        $display("FAIL to_alone: got v%b idx%0d want v1 idx0", valid_r, idx_r);
      end
    end
`else
    repeat (100) begin
      step();
      n_cmp++;
      if ({valid_r, idx_r} !== 3'b1_00) begin
        n_bad++;
        $display("FAIL no_timeout: got v%b idx%0d want v1 idx0", valid_r, idx_r);
      end
    end
`endif
    n_cmp++;
    if ({valid_r, idx_r, grant_r} !== exp_r()) begin
      n_bad++;
      $display("FAIL to_model: got %h want %h", {valid_r, idx_r, grant_r}, exp_r());
    end
    req_r = '0;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_f = 4'($urandom);
      req_r = 3'($urandom);
      if (own_f >= 0 && $urandom_range(3) != 0) req_f[own_f] = 1'b1;
      if (own_r >= 0 && $urandom_range(3) != 0) req_r[own_r] = 1'b1;
      step();
      n_cmp++;
      if ({valid_f, idx_f, grant_f} !== exp_f()) begin
        n_bad++;
        $display("FAIL rand_fix[%0d]: got %h want %h", c,
                 {valid_f, idx_f, grant_f}, exp_f());
      end
      n_cmp++;
      if ({valid_r, idx_r, grant_r} !== exp_r()) begin
        n_bad++;
        $display("FAIL rand_rr[%0d]: got %h want %h", c,
                 {valid_r, idx_r, grant_r}, exp_r());
      end
    end
    req_f = '0;
    req_r = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_encoder();
    test_handoff();
    test_rr_fair();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
